// File: rtl/instr_scheduler_pkg.sv
// Shared definitions for the matrix coprocessor instruction scheduler:
// opcode values, opcode field position, sequencer state encoding and opcode classifiers.
package instr_scheduler_pkg;

    localparam int OPC_MSB = 3;
    localparam int OPC_LSB = 0;

    localparam logic [3:0] OPC_READ  = 4'd1;
    localparam logic [3:0] OPC_WRITE = 4'd2;
    localparam logic [3:0] OPC_SUM   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MUL   = 4'd5;
    localparam logic [3:0] OPC_TRANS = 4'd6;
    localparam logic [3:0] OPC_SCALE = 4'd7;
    localparam logic [3:0] OPC_DOT   = 4'd8;
    localparam logic [3:0] OPC_DET2  = 4'd9;
    localparam logic [3:0] OPC_DET3  = 4'd10;
    localparam logic [3:0] OPC_DET4  = 4'd11;
    localparam logic [3:0] OPC_DET5  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_WAIT    = 2'b10,
        ST_CAPTURE = 2'b11
    } state_t;

    function automatic logic opc_legal(input logic [3:0] opc);
        return (opc >= OPC_READ) && (opc <= OPC_DET5);
    endfunction

    function automatic logic opc_arith(input logic [3:0] opc);
        return (opc >= OPC_SUM) && (opc <= OPC_DET5);
    endfunction

endpackage

// File: rtl/instr_scheduler_fifo.sv
// Instruction FIFO: power-of-two depth, wrapping pointers, occupancy count,
// head word visible combinationally so the sequencer can pop and latch it in one cycle.
module instr_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int CW = AW + 1;

    logic [W-1:0]  mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage is not reset: only entries covered by count are ever read out.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
        end
    end

endmodule

// File: rtl/instr_scheduler.sv
// Instruction queue and sequencer for the matrix coprocessor: issues queued words one at a time,
// waits for completion under a watchdog, and captures read data / overflow for the host.
module instr_scheduler
    import instr_scheduler_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] host_instr,
    input  logic        host_valid,
    output logic        host_ready,
    output logic [31:0] core_instr,
    output logic        core_activate,
    input  logic        core_done,
    input  logic [15:0] core_data,
    input  logic        core_ovf,
    output logic [15:0] res_data,
    output logic        res_ovf,
    output logic        res_valid,
    output logic        busy,
    output logic [AW:0] fifo_count,
    output logic        err_illegal,
    output logic        err_timeout,
    input  logic        err_clr
);

    localparam int WDW = $clog2(TIMEOUT) + 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [WDW-1:0] WD_MAX  = '1;

    state_t        state_reg;
    state_t        state_next;
    logic [WDW-1:0] wd_reg;
    logic [31:0]   core_instr_reg;
    logic [15:0]   res_data_reg;
    logic          res_ovf_reg;
    logic          err_illegal_reg;
    logic          err_timeout_reg;

    logic [31:0]   fifo_rd_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          set_illegal;
    logic          set_timeout;
    logic          do_capture;
    logic [3:0]    head_opc;
    logic [3:0]    cur_opc;

    instr_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (host_valid),
        .wr_data (host_instr),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign head_opc = fifo_rd_data[OPC_MSB:OPC_LSB];
    assign cur_opc  = core_instr_reg[OPC_MSB:OPC_LSB];

    always_comb begin
        state_next  = state_reg;
        fifo_pop    = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        do_capture  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (opc_legal(head_opc)) begin
                        state_next = ST_ISSUE;
                    end else begin
                        set_illegal = 1'b1;
                    end
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (core_done) begin
                    do_capture = 1'b1;
                    state_next = ST_CAPTURE;
                end else if (wd_reg == WD_LAST) begin
                    set_timeout = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Result registers sample on the core_done edge, when core_data/core_ovf are paired with
    // the done pulse, so they already hold the new values while res_valid is high in CAPTURE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            wd_reg          <= '0;
            core_instr_reg  <= '0;
            res_data_reg    <= '0;
            res_ovf_reg     <= 1'b0;
            err_illegal_reg <= 1'b0;
            err_timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (fifo_pop) begin
                core_instr_reg <= fifo_rd_data;
            end
            if (state_reg == ST_ISSUE) begin
                wd_reg <= '0;
            end else if (state_reg == ST_WAIT && wd_reg != WD_MAX) begin
                wd_reg <= wd_reg + WDW'(1);
            end
            if (do_capture) begin
                if (cur_opc == OPC_READ) begin
                    res_data_reg <= core_data;
                end
                if (opc_arith(cur_opc)) begin
                    res_ovf_reg <= core_ovf;
                end
            end
            // A new error in the same cycle as err_clr keeps the flag set.
            if (set_illegal) begin
                err_illegal_reg <= 1'b1;
            end else if (err_clr) begin
                err_illegal_reg <= 1'b0;
            end
            if (set_timeout) begin
                err_timeout_reg <= 1'b1;
            end else if (err_clr) begin
                err_timeout_reg <= 1'b0;
            end
        end
    end

    assign host_ready    = !fifo_full;
    assign core_instr    = core_instr_reg;
    assign core_activate = (state_reg == ST_ISSUE);
    assign res_valid     = (state_reg == ST_CAPTURE);
    assign res_data      = res_data_reg;
    assign res_ovf       = res_ovf_reg;
    assign busy          = (state_reg != ST_IDLE) || !fifo_empty;
    assign err_illegal   = err_illegal_reg;
    assign err_timeout   = err_timeout_reg;

endmodule

// File: tb/tb_instr_scheduler.sv
// Directed bench for instr_scheduler: a table of single-instruction transactions plus
// hand-written sequences for queueing, full FIFO, errors, watchdog and mid-operation reset.
module tb_instr_scheduler;

    localparam int TIMEOUT = 4096;

    logic        clk;
    logic        rst_n;
    logic [31:0] host_instr;
    logic        host_valid;
    logic        host_ready;
    logic [31:0] core_instr;
    logic        core_activate;
    logic        core_done;
    logic [15:0] core_data;
    logic        core_ovf;
    logic [15:0] res_data;
    logic        res_ovf;
    logic        res_valid;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        err_illegal;
    logic        err_timeout;
    logic        err_clr;

    int pass_cnt = 0;
    int total_cnt = 0;

    instr_scheduler #(
        .DEPTH   (8),
        .AW      (3),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_instr    (host_instr),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .core_instr    (core_instr),
        .core_activate (core_activate),
        .core_done     (core_done),
        .core_data     (core_data),
        .core_ovf      (core_ovf),
        .res_data      (res_data),
        .res_ovf       (res_ovf),
        .res_valid     (res_valid),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .err_illegal   (err_illegal),
        .err_timeout   (err_timeout),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] data;
        logic        ovf;
        int          delay;
        logic [15:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic push(input logic [31:0] w);
        host_instr = w;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic wait_activate(input logic [31:0] exp_instr, input string name);
        int n;
        n = 0;
        while (core_activate !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({name, "_activate"}, core_activate, 1);
        check({name, "_instr"}, core_instr, exp_instr);
    endtask

    // Called while the DUT is in WAIT: pulse core_done and check the capture.
    task automatic finish_op(input logic [15:0] data, input logic ovf,
                             input logic [15:0] exp_data, input logic exp_ovf, input string name);
        core_done = 1'b1;
        core_data = data;
        core_ovf  = ovf;
        tick();
        core_done = 1'b0;
        check({name, "_res_valid"}, res_valid, 1);
        check({name, "_res_data"}, res_data, exp_data);
        check({name, "_res_ovf"}, res_ovf, exp_ovf);
        tick();
        check({name, "_res_valid_end"}, res_valid, 0);
        $display("op %s: instr=%h res_data=%h res_ovf=%0b", name, core_instr, res_data, res_ovf);
    endtask

    initial begin
        int  n;
        bit  rv;
        logic [31:0] w;

        rst_n = 1'b0; host_instr = 32'h0000_0051; host_valid = 1'b1;
        core_done = 1'b0; core_data = '0; core_ovf = 1'b0; err_clr = 1'b0;

        // 1: reset with host_valid high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_count", fifo_count, 0);
            check("rst_activate", core_activate, 0);
            check("rst_ready", host_ready, 1);
        end
        check("rst_busy", busy, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_core_instr", core_instr, 0);
        check("rst_errs", {err_illegal, err_timeout}, 0);
        host_valid = 1'b0;
        rst_n = 1'b1;
        tick();

        // 2: single-instruction table (empty queue, so activate lands at push+2)
        vecs[0] = '{32'h0000_0051, 16'hBEEF, 1'b0, 10, 16'hBEEF, 1'b0};
        vecs[1] = '{32'h0000_0123, 16'h1111, 1'b1,  3, 16'hBEEF, 1'b1};
        vecs[2] = '{32'h0000_0042, 16'h2222, 1'b0,  2, 16'hBEEF, 1'b1};
        vecs[3] = '{32'h0000_008C, 16'h3333, 1'b0,  1, 16'hBEEF, 1'b0};
        vecs[4] = '{32'hABCD_0001, 16'h1234, 1'b1,  4, 16'h1234, 1'b0};
        vecs[5] = '{32'h0000_0094, 16'h4444, 1'b1,  2, 16'h1234, 1'b1};
        for (int v = 0; v < 6; v++) begin
            push(vecs[v].instr);
            check($sformatf("v%0d_lat_n1", v), core_activate, 0);
            tick();
            check($sformatf("v%0d_lat_n2", v), core_activate, 1);
            check($sformatf("v%0d_instr", v), core_instr, vecs[v].instr);
            tick();
            check($sformatf("v%0d_pulse_end", v), core_activate, 0);
            repeat (vecs[v].delay - 1) tick();
            finish_op(vecs[v].data, vecs[v].ovf, vecs[v].exp_data, vecs[v].exp_ovf,
                      $sformatf("v%0d", v));
        end

        // 3: back-to-back SUM, MUL, WRITE queued behind the first
        push(32'h0000_0203);
        wait_activate(32'h0000_0203, "b2b_sum");
        tick();
        push(32'h0000_0505);
        push(32'h0000_0702);
        check("b2b_count", fifo_count, 2);
        finish_op(16'h0101, 1'b0, 16'h1234, 1'b0, "b2b_sum");
        wait_activate(32'h0000_0505, "b2b_mul");
        tick();
        finish_op(16'h0202, 1'b1, 16'h1234, 1'b1, "b2b_mul");
        wait_activate(32'h0000_0702, "b2b_write");
        tick();
        finish_op(16'h5555, 1'b0, 16'h1234, 1'b1, "b2b_write");

        // simultaneous push and pop leaves the count unchanged
        host_instr = 32'h0000_0A03; host_valid = 1'b1;
        tick();
        check("pp_count_a", fifo_count, 1);
        host_instr = 32'h0000_0B04;
        tick();
        host_valid = 1'b0;
        check("pp_count_b", fifo_count, 1);
        check("pp_activate", core_activate, 1);
        check("pp_instr", core_instr, 32'h0000_0A03);
        tick();
        finish_op(16'h0303, 1'b0, 16'h1234, 1'b0, "pp_a");
        wait_activate(32'h0000_0B04, "pp_b");
        tick();
        finish_op(16'h0404, 1'b1, 16'h1234, 1'b1, "pp_b");

        // 4: full FIFO behind a stalled READ
        push(32'h0000_0C01);
        wait_activate(32'h0000_0C01, "full_stall");
        tick();
        host_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = 32'h0001_0003 | (i << 8);
            host_instr = w;
            check($sformatf("full_ready%0d", i), host_ready, (i < 8) ? 1 : 0);
            tick();
        end
        host_valid = 1'b0;
        check("full_count", fifo_count, 8);
        check("full_ready_low", host_ready, 0);
        finish_op(16'hCAFE, 1'b1, 16'hCAFE, 1'b1, "full_stall");
        for (int i = 0; i < 8; i++) begin
            w = 32'h0001_0003 | (i << 8);
            wait_activate(w, $sformatf("drain%0d", i));
            tick();
            finish_op(16'h0000, i[0], 16'hCAFE, i[0], $sformatf("drain%0d", i));
        end
        check("drain_count", fifo_count, 0);
        check("drain_busy", busy, 0);

        // 5: illegal opcodes and watchdog
        push(32'h0000_000F);
        check("ill_no_act0", core_activate, 0);
        tick();
        check("ill_flag", err_illegal, 1);
        check("ill_no_act1", core_activate, 0);
        tick();
        check("ill_no_act2", core_activate, 0);
        check("ill_busy", busy, 0);

        push(32'h0000_0D03);
        push(32'h0000_0E01);
        wait_activate(32'h0000_0D03, "to_sum");
        n = 0;
        rv = 1'b0;
        while (err_timeout !== 1'b1 && n < TIMEOUT + 100) begin
            tick();
            n++;
            if (res_valid === 1'b1) rv = 1'b1;
        end
        check("to_cycles", n, TIMEOUT + 1);
        check("to_no_res_valid", rv, 0);
        check("to_activate", core_activate, 0);
        wait_activate(32'h0000_0E01, "to_next");
        tick();
        finish_op(16'h7777, 1'b0, 16'h7777, 1'b1, "to_next");

        // core_done outside WAIT is ignored
        core_done = 1'b1; core_data = 16'h9999;
        tick();
        core_done = 1'b0;
        check("stray_done_valid", res_valid, 0);
        tick();
        check("stray_done_data", res_data, 16'h7777);

        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_flags", {err_illegal, err_timeout}, 0);

        // opcode 0 is illegal; then clear racing a new illegal opcode 13
        push(32'h0000_0100);
        tick();
        check("ill0_flag", err_illegal, 1);
        check("ill0_no_act", core_activate, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ill0_clr", err_illegal, 0);
        push(32'h0000_00ED);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_wins", err_illegal, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_wins_clr", err_illegal, 0);

        // 6: reset during WAIT
        push(32'h0000_0F01);
        wait_activate(32'h0000_0F01, "mid_rst");
        tick();
        push(32'h0000_1003);
        push(32'h0000_1103);
        check("mid_rst_qcount", fifo_count, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", res_valid, 0);
        core_done = 1'b1; core_data = 16'hDEAD;
        tick();
        core_done = 1'b0;
        check("mid_rst_done_valid", res_valid, 0);
        rv = 1'b0;
        repeat (4) begin
            tick();
            if (core_activate === 1'b1 || res_valid === 1'b1) rv = 1'b1;
        end
        check("mid_rst_quiet", rv, 0);
        check("mid_rst_res_data", res_data, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
